// File: rtl/lsu_mhq.sv
// Miss Handling Queue: a circular FIFO of outstanding line fetches.
// Load misses are matched against in-flight lines. Unmatched misses take a
// new slot, or get a retry if the queue is full. Slots send line requests
// to memory in allocation order. Memory responses, which arrive in request
// order, are broadcast one cycle later as a fill of tag, address and data.
module lsu_mhq #(
  parameter int MHQ_DEPTH     = 4,
  parameter int MHQ_TAG_WIDTH = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int OFFSET_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_lookup_en,
  input  logic [ADDR_WIDTH-1:0]    i_lookup_addr,
  output logic [MHQ_TAG_WIDTH-1:0] o_lookup_tag,
  output logic                     o_lookup_retry,
  output logic                     o_full,
  output logic                     o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]    o_mem_req_addr,
  input  logic                     i_mem_req_ready,
  input  logic                     i_mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0]    i_mem_rsp_data,
  output logic                     o_mhq_fill,
  output logic [MHQ_TAG_WIDTH-1:0] o_mhq_fill_tag,
  output logic [ADDR_WIDTH-1:0]    o_mhq_fill_addr,
  output logic [LINE_WIDTH-1:0]    o_mhq_fill_data
);

  localparam int LINE_AW = ADDR_WIDTH - OFFSET_WIDTH;

  localparam logic [1:0] ST_INVALID = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_ISSUED  = 2'd2;
  localparam logic [1:0] ST_FILLING = 2'd3;

  localparam logic [MHQ_TAG_WIDTH:0]   COUNT_FULL = (MHQ_TAG_WIDTH+1)'(MHQ_DEPTH);
  localparam logic [MHQ_TAG_WIDTH:0]   COUNT_ONE  = (MHQ_TAG_WIDTH+1)'(1);
  localparam logic [MHQ_TAG_WIDTH-1:0] TAG_ONE    = MHQ_TAG_WIDTH'(1);

  // Per-slot state and line address, collected into packed vectors so that
  // the pointers can index them.
  logic [MHQ_DEPTH-1:0][1:0]         state_vec;
  logic [MHQ_DEPTH-1:0][LINE_AW-1:0] line_vec;
  logic [MHQ_DEPTH-1:0]              hit_vec;

  logic [MHQ_TAG_WIDTH-1:0] tail_reg;
  logic [MHQ_TAG_WIDTH-1:0] issue_reg;
  logic [MHQ_TAG_WIDTH-1:0] head_reg;
  logic [MHQ_TAG_WIDTH:0]   count_reg;

  logic                     fill_valid_reg;
  logic [MHQ_TAG_WIDTH-1:0] fill_tag_reg;
  logic [ADDR_WIDTH-1:0]    fill_addr_reg;
  logic [LINE_WIDTH-1:0]    fill_data_reg;

  logic [LINE_AW-1:0]       lookup_line;
  logic                     lookup_hit;
  logic [MHQ_TAG_WIDTH-1:0] hit_idx;
  logic                     full;
  logic                     alloc;
  logic                     req_fire;
  logic                     rsp_accept;

  assign lookup_line = i_lookup_addr[ADDR_WIDTH-1:OFFSET_WIDTH];

  // A slot in its FILLING cycle has already been handed back, so it does
  // not count toward "full". With a full queue that slot is the tail slot.
  assign full  = (count_reg == COUNT_FULL) && !fill_valid_reg;
  assign alloc = i_lookup_en && !lookup_hit && !full;

  assign o_mem_req_valid = (state_vec[issue_reg] == ST_PENDING);
  assign o_mem_req_addr  = {line_vec[issue_reg], {OFFSET_WIDTH{1'b0}}};
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;

  // A response that does not match an ISSUED head slot is stale, for
  // example one that arrives after a reset. It is dropped.
  assign rsp_accept = i_mem_rsp_valid && (state_vec[head_reg] == ST_ISSUED);

  // Per-slot storage and CAM compare
  for (genvar gi = 0; gi < MHQ_DEPTH; gi++) begin : g_slot
    localparam logic [MHQ_TAG_WIDTH-1:0] SLOT = MHQ_TAG_WIDTH'(gi);

    logic [1:0]         state_reg;
    logic [LINE_AW-1:0] line_reg;

    assign state_vec[gi] = state_reg;
    assign line_vec[gi]  = line_reg;
    // FILLING slots are excluded: their broadcast is already committed.
    assign hit_vec[gi]   = ((state_reg == ST_PENDING) || (state_reg == ST_ISSUED)) &&
                           (line_reg == lookup_line);

    // Slot lifecycle. Reallocation takes priority over the end-of-fill release.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg <= ST_INVALID;
      end else if (alloc && (tail_reg == SLOT)) begin
        state_reg <= ST_PENDING;
      end else if (req_fire && (issue_reg == SLOT)) begin
        state_reg <= ST_ISSUED;
      end else if (rsp_accept && (head_reg == SLOT)) begin
        state_reg <= ST_FILLING;
      end else if (fill_valid_reg && (fill_tag_reg == SLOT)) begin
        state_reg <= ST_INVALID;
      end
    end

    // Line address is captured on allocation and stays stable while PENDING.
    always_ff @(posedge clk) begin
      if (rst) begin
        line_reg <= '0;
      end else if (alloc && (tail_reg == SLOT)) begin
        line_reg <= lookup_line;
      end
    end
  end

  // Pick the matching slot. At most one PENDING/ISSUED slot can hold a given line.
  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    for (int i = MHQ_DEPTH - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        lookup_hit = 1'b1;
        hit_idx    = MHQ_TAG_WIDTH'(i);
      end
    end
  end

  // Lookup response: the matching tag, the newly allocated tag, or a retry
  always_comb begin
    o_lookup_tag   = '0;
    o_lookup_retry = 1'b0;
    if (i_lookup_en) begin
      if (lookup_hit) begin
        o_lookup_tag = hit_idx;
      end else if (full) begin
        o_lookup_retry = 1'b1;
      end else begin
        o_lookup_tag = tail_reg;
      end
    end
  end

  assign o_full = full;

  // Allocation, issue and response pointers. The occupancy count drops when
  // the fill broadcast retires a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_reg  <= '0;
      issue_reg <= '0;
      head_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc)      tail_reg  <= tail_reg + TAG_ONE;
      if (req_fire)   issue_reg <= issue_reg + TAG_ONE;
      if (rsp_accept) head_reg  <= head_reg + TAG_ONE;
      case ({alloc, fill_valid_reg})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Fill register: captures the accepted response and broadcasts it next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_valid_reg <= 1'b0;
      fill_tag_reg   <= '0;
      fill_addr_reg  <= '0;
      fill_data_reg  <= '0;
    end else begin
      fill_valid_reg <= rsp_accept;
      if (rsp_accept) begin
        fill_tag_reg  <= head_reg;
        fill_addr_reg <= {line_vec[head_reg], {OFFSET_WIDTH{1'b0}}};
        fill_data_reg <= i_mem_rsp_data;
      end
    end
  end

  assign o_mhq_fill      = fill_valid_reg;
  assign o_mhq_fill_tag  = fill_tag_reg;
  assign o_mhq_fill_addr = fill_addr_reg;
  assign o_mhq_fill_data = fill_data_reg;

endmodule

// File: tb/tb_lsu_mhq.sv
// Testbench for lsu_mhq. A queue-based reference model predicts the outputs
// on every cycle. Directed scenarios pin literal values, then a randomized
// phase runs against the model.
module tb_lsu_mhq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_lookup_en = 1'b0;
  logic [31:0]  i_lookup_addr = '0;
  logic [1:0]   o_lookup_tag;
  logic         o_lookup_retry;
  logic         o_full;
  logic         o_mem_req_valid;
  logic [31:0]  o_mem_req_addr;
  logic         i_mem_req_ready = 1'b0;
  logic         i_mem_rsp_valid = 1'b0;
  logic [127:0] i_mem_rsp_data = '0;
  logic         o_mhq_fill;
  logic [1:0]   o_mhq_fill_tag;
  logic [31:0]  o_mhq_fill_addr;
  logic [127:0] o_mhq_fill_data;

  lsu_mhq dut (
    .clk(clk), .rst(rst),
    .i_lookup_en(i_lookup_en), .i_lookup_addr(i_lookup_addr),
    .o_lookup_tag(o_lookup_tag), .o_lookup_retry(o_lookup_retry), .o_full(o_full),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_req_ready(i_mem_req_ready),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
    .o_mhq_fill(o_mhq_fill), .o_mhq_fill_tag(o_mhq_fill_tag),
    .o_mhq_fill_addr(o_mhq_fill_addr), .o_mhq_fill_data(o_mhq_fill_data)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding misses in allocation order.
  typedef struct {
    logic [27:0] line;
    logic [1:0]  slot;
    bit          issued;
  } ent_t;

  ent_t         mq[$];
  logic [1:0]   m_tail;
  bit           fp_valid;
  logic [1:0]   fp_tag;
  logic [31:0]  fp_addr;
  logic [127:0] fp_data;
  bit           known = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int req_fires = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive the inputs, compare the outputs, advance the model.
  task automatic step(input bit en, input logic [31:0] addr, input bit rdy,
                      input bit rv, input logic [127:0] rd, input bit r);
    bit         hit;
    logic [1:0] hslot;
    bit         efull;
    logic [1:0] etag;
    bit         eretry;
    int         ri;
    bit         alloc;
    bit         take;
    ent_t       popped;
    ent_t       ne;
    @(negedge clk);
    rst = r; i_lookup_en = en; i_lookup_addr = addr;
    i_mem_req_ready = rdy; i_mem_rsp_valid = rv; i_mem_rsp_data = rd;
    #1;
    hit = 0; hslot = 0;
    foreach (mq[i]) if (mq[i].line == addr[31:4]) begin hit = 1; hslot = mq[i].slot; end
    efull = (mq.size() == 4);
    ri = -1;
    for (int i = mq.size() - 1; i >= 0; i--) if (!mq[i].issued) ri = i;
    etag = 0; eretry = 0;
    if (en) begin
      if (hit) etag = hslot;
      else if (efull) eretry = 1;
      else etag = m_tail;
    end
    if (known) begin
      chk("full", 128'(o_full), 128'(efull));
      chk("lookup_tag", 128'(o_lookup_tag), 128'(etag));
      chk("lookup_retry", 128'(o_lookup_retry), 128'(eretry));
      chk("req_valid", 128'(o_mem_req_valid), 128'(ri >= 0));
      if (ri >= 0) chk("req_addr", 128'(o_mem_req_addr), 128'({mq[ri].line, 4'h0}));
      chk("fill", 128'(o_mhq_fill), 128'(fp_valid));
      if (fp_valid) begin
        chk("fill_tag", 128'(o_mhq_fill_tag), 128'(fp_tag));
        chk("fill_addr", 128'(o_mhq_fill_addr), 128'(fp_addr));
        chk("fill_data", o_mhq_fill_data, fp_data);
      end
    end
    if (o_mem_req_valid && rdy) req_fires++;
    // model advance
    if (r) begin
      mq.delete(); m_tail = 0; fp_valid = 0; known = 1;
    end else begin
      alloc = en && !hit && !efull;
      take = rv && (mq.size() > 0) && mq[0].issued;
      if (ri >= 0 && rdy) mq[ri].issued = 1;
      fp_valid = 0;
      if (take) begin
        popped = mq.pop_front();
        fp_valid = 1; fp_tag = popped.slot;
        fp_addr = {popped.line, 4'h0}; fp_data = rd;
      end
      if (alloc) begin
        ne.line = addr[31:4]; ne.slot = m_tail; ne.issued = 0;
        mq.push_back(ne);
        m_tail = m_tail + 2'd1;
      end
    end
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask
  task automatic lk(input logic [31:0] a); step(1, a, 0, 0, 0, 0); endtask
  task automatic do_reset(); step(0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 1); endtask

  // Issue and answer everything outstanding, bounded by a cycle budget.
  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (mq.size() == 0 && !fp_valid) done = 1;
      else step(0, 0, 1, (mq.size() > 0) && mq[0].issued, rnd_data(), 0);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: queue not empty after cycle budget, %0d left", mq.size());
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [31:0]  a;
    int           fires0;

    // Basic miss, fetch and fill
    do_reset();
    idle();
    chk("rst_full", 128'(o_full), 128'(0));
    chk("rst_req_valid", 128'(o_mem_req_valid), 128'(0));
    chk("rst_fill", 128'(o_mhq_fill), 128'(0));
    lk(32'h1004);
    chk("t1_tag", 128'(o_lookup_tag), 128'(0));
    chk("t1_retry", 128'(o_lookup_retry), 128'(0));
    idle();
    chk("t1_req_valid", 128'(o_mem_req_valid), 128'(1));
    chk("t1_req_addr", 128'(o_mem_req_addr), 128'(32'h1000));
    step(0, 0, 1, 0, 0, 0);
    d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    step(0, 0, 0, 1, d, 0);
    idle();
    chk("t1_fill", 128'(o_mhq_fill), 128'(1));
    chk("t1_fill_tag", 128'(o_mhq_fill_tag), 128'(0));
    chk("t1_fill_addr", 128'(o_mhq_fill_addr), 128'(32'h1000));
    chk("t1_fill_data", o_mhq_fill_data, d);
    idle();
    chk("t1_fill_done", 128'(o_mhq_fill), 128'(0));

    // Two lookups to the same line share one entry and one request
    do_reset();
    lk(32'h2000);
    chk("t2_tag_a", 128'(o_lookup_tag), 128'(0));
    lk(32'h200C);
    chk("t2_tag_b", 128'(o_lookup_tag), 128'(0));
    fires0 = req_fires;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
    chk("t2_one_request", 128'(req_fires - fires0), 128'(1));
    drain();

    // Fill the queue, get a retry, then reuse the freed slot in the fill cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000 * (i + 1);
      lk(a);
      chk("t3_tag", 128'(o_lookup_tag), 128'(i));
    end
    lk(32'h5000);
    chk("t3_retry", 128'(o_lookup_retry), 128'(1));
    chk("t3_full", 128'(o_full), 128'(1));
    chk("t3_retry_tag", 128'(o_lookup_tag), 128'(0));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, rnd_data(), 0);
    lk(32'h5000);
    chk("t3_fill_full", 128'(o_full), 128'(0));
    chk("t3_fill_tag", 128'(o_lookup_tag), 128'(0));
    chk("t3_fill_retry", 128'(o_lookup_retry), 128'(0));
    drain();

    // Request stays stable under backpressure; tags wrap around
    do_reset();
    for (int k = 0; k < 6; k++) begin
      a = 32'h0001_0000 + 32'h100 * k;
      lk(a);
      chk("t4_tag", 128'(o_lookup_tag), 128'(k % 4));
      if (k == 0) begin
        for (int j = 0; j < 5; j++) begin
          idle();
          chk("t4_hold_valid", 128'(o_mem_req_valid), 128'(1));
          chk("t4_hold_addr", 128'(o_mem_req_addr), 128'(a));
        end
      end
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, rnd_data(), 0);
      idle();
      chk("t4_fill_tag", 128'(o_mhq_fill_tag), 128'(k % 4));
    end

    // Lookup in the response cycle hits; lookup in the fill cycle reallocates
    do_reset();
    lk(32'h3000);
    step(0, 0, 1, 0, 0, 0);
    step(1, 32'h3000, 0, 1, rnd_data(), 0);
    chk("t5_hit_tag", 128'(o_lookup_tag), 128'(0));
    chk("t5_hit_retry", 128'(o_lookup_retry), 128'(0));
    lk(32'h3000);
    chk("t5_new_tag", 128'(o_lookup_tag), 128'(1));
    chk("t5_fill", 128'(o_mhq_fill), 128'(1));
    idle();
    chk("t5_new_req", 128'(o_mem_req_valid), 128'(1));
    chk("t5_new_addr", 128'(o_mem_req_addr), 128'(32'h3000));
    drain();

    // Reset drops issued entries; stale responses are ignored
    do_reset();
    lk(32'h7000); lk(32'h8000); lk(32'h9000);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, rnd_data(), 0);
    lk(32'hA000);
    chk("t6_no_fill", 128'(o_mhq_fill), 128'(0));
    chk("t6_tag", 128'(o_lookup_tag), 128'(0));
    drain();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit en, rdy, rv, r;
      en  = ($urandom_range(0, 99) < 45);
      a   = 32'h1000 * $urandom_range(1, 6) + $urandom_range(0, 15);
      rdy = ($urandom_range(0, 99) < 60);
      if (mq.size() > 0 && mq[0].issued) rv = ($urandom_range(0, 99) < 50);
      else rv = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 299) == 0);
      step(en, a, rdy, rv, rnd_data(), r);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mhq.md
Name: lsu_mhq

Overview:
Miss Handling Queue. It is the responder side of the LQ replay protocol: it accepts cache-miss lookups from LSU_EX, returns an MHQ tag or a retry indication, and issues line fetches to memory. It broadcasts a fill (tag, address, line data) that wakes waiting loads in the LQ and writes the D-cache. It is a circular FIFO with in-order memory responses.

Parameters:
MHQ_DEPTH, 4, number of entries (power of two, ≥2)
MHQ_TAG_WIDTH, 2, log2(MHQ_DEPTH); tag = slot index
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 128, cacheline data bits
OFFSET_WIDTH, 4, log2(LINE_WIDTH/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_lookup_en  in  1  LSU_EX reports a load miss this cycle
i_lookup_addr  in  ADDR_WIDTH  miss byte address
o_lookup_tag  out  MHQ_TAG_WIDTH  MHQ tag the load must wait on (comb)
o_lookup_retry  out  1  MHQ full, no match; load waits on any fill (comb)
o_full  out  1  no entry available this cycle
o_mem_req_valid  out  1  line fetch request valid
o_mem_req_addr  out  ADDR_WIDTH  line-aligned request address (offset bits zero)
i_mem_req_ready  in  1  memory accepts request
i_mem_rsp_valid  in  1  line data returned (in request order)
i_mem_rsp_data  in  LINE_WIDTH  line data
o_mhq_fill  out  1  one-cycle fill broadcast
o_mhq_fill_tag  out  MHQ_TAG_WIDTH  tag of filled entry
o_mhq_fill_addr  out  ADDR_WIDTH  line-aligned fill address
o_mhq_fill_data  out  LINE_WIDTH  fill line data

Behaviour:
- Entry fields: state {INVALID, PENDING, ISSUED, FILLING}, line address (ADDR_WIDTH-OFFSET_WIDTH bits).
- Pointers: tail (alloc), issue (next request), head (next response); all wrap modulo MHQ_DEPTH. count is 0..MHQ_DEPTH, MHQ_TAG_WIDTH+1 bits.
- Reset: all entries INVALID; pointers and count 0; o_mhq_fill, o_mem_req_valid, o_full, o_lookup_retry, o_lookup_tag, fill register all 0. Reset mid-operation drops all entries. Responses arriving while the head entry is not ISSUED are discarded.
- Lookup (combinational, same cycle as i_lookup_en):
  - CAM line address against PENDING/ISSUED entries. FILLING entries are excluded.
  - Hit: o_lookup_tag = matching slot, retry=0, no allocation.
  - Miss and ~o_full: allocate slot tail as PENDING at the clock edge; o_lookup_tag = tail; tail++.
  - Miss and o_full: retry=1, tag=0.
  - When i_lookup_en=0, both outputs are 0.
- o_full = (count == MHQ_DEPTH) && ~o_mhq_fill. A slot in its FILLING cycle may be reallocated that same cycle, so with a full queue it is the slot at tail.
- Request: o_mem_req_valid = entry[issue].state==PENDING. addr = {line,0}. On valid&&ready the entry becomes ISSUED and issue++. The request is held stable until ready.
- Response at cycle N:
  - Capture {head, head line addr, data} into the fill register.
  - entry[head] → FILLING; head++.
- Cycle N+1:
  - o_mhq_fill=1 with the registered tag/addr/data.
  - The FILLING slot → INVALID at the end of N+1, unless reallocated that cycle.
  - count decrements.
- Back-to-back responses are supported (fill every cycle).
- A lookup in cycle N hitting the head entry returns its tag, so the LQ marks the load before the N+1 broadcast.
- A lookup in N+1 for the same line misses and allocates a fresh entry (redundant fetch accepted).
- Simultaneous allocate and fill decrement: count unchanged.
- The MHQ ignores pipeline flush; outstanding fetches always complete.

Test Plan:
- Reset, then lookup 0x1004 → tag=0, retry=0. Next cycle o_mem_req_valid=1, addr=0x1000. After ready, response data D: one cycle later o_mhq_fill=1, tag=0, addr=0x1000, data=D; count returns to 0.
- Two lookups to 0x2000 then 0x200C (before the response) → both return tag 0; exactly one memory request is issued.
- Lookups to 4 distinct lines fill the queue; a 5th lookup with no fill → retry=1, o_full=1. In the fill cycle, a lookup to a new line → o_full=0, tag = freed slot, retry=0.
- Hold i_mem_req_ready=0 for 5 cycles → o_mem_req_valid and addr stay stable; pointers wrap correctly after 6 alloc/fill pairs (tags 0,1,2,3,0,1).
- Response in cycle N for line 0x3000 with a lookup 0x3000 in N → tag=head. A lookup 0x3000 in N+1 → new tag allocated and a new request issued.
- Assert rst with 3 entries ISSUED; a later response → no o_mhq_fill; next lookup → tag=0.
